// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block memory between the data and instruction caches.
// Every transaction is an ISSUE cycle followed by WAIT, and at least one IDLE cycle separates transactions.
module mem_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        dcache_read,
   input  logic        dcache_write,
   input  logic [5:0]  dcache_address,
   input  logic [31:0] dcache_writedata,
   output logic [31:0] dcache_readdata,
   output logic        dcache_busywait,
   input  logic        icache_read,
   input  logic [5:0]  icache_address,
   output logic [31:0] icache_readdata,
   output logic        icache_busywait,
   output logic        mem_read,
   output logic        mem_write,
   output logic [5:0]  mem_address,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   input  logic        mem_busywait
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      D_ISSUE = 3'd1,
      D_WAIT  = 3'd2,
      I_ISSUE = 3'd3,
      I_WAIT  = 3'd4
   } state_t;

   state_t state;
   logic   last_grant;   // 0 = dcache, 1 = icache
   logic   dreq;
   logic   ireq;
   logic   d_owner;
   logic   i_owner;
   logic   d_done;
   logic   i_done;

   assign dreq = dcache_read | dcache_write;
   assign ireq = icache_read;

   // On a tie the requester that was not granted last wins.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (dreq && (!ireq || last_grant)) begin
                  state      <= D_ISSUE;
                  last_grant <= 1'b0;
               end else if (ireq) begin
                  state      <= I_ISSUE;
                  last_grant <= 1'b1;
               end
            end
            D_ISSUE: state <= D_WAIT;
            D_WAIT:  if (!mem_busywait) state <= IDLE;
            I_ISSUE: state <= I_WAIT;
            I_WAIT:  if (!mem_busywait) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign d_owner = !reset && (state == D_ISSUE || state == D_WAIT);
   assign i_owner = !reset && (state == I_ISSUE || state == I_WAIT);

   // Completion is suppressed under reset so an aborted transfer never releases a requester.
   assign d_done = !reset && state == D_WAIT && !mem_busywait;
   assign i_done = !reset && state == I_WAIT && !mem_busywait;

   assign dcache_busywait = dreq & ~d_done;
   assign icache_busywait = ireq & ~i_done;
   assign dcache_readdata = mem_readdata;
   assign icache_readdata = mem_readdata;

   // Memory port is steered by the current owner; write wins over read for the dcache.
   always_comb begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = 6'd0;
      mem_writedata = 32'd0;
      if (d_owner) begin
         mem_write     = dcache_write;
         mem_read      = !dcache_write;
         mem_address   = dcache_address;
         mem_writedata = dcache_writedata;
      end else if (i_owner) begin
         mem_read      = 1'b1;
         mem_address   = icache_address;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random stimulus for mem_arbiter, checked every cycle against a transaction-level model.
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        dcache_read = 1'b0;
   logic        dcache_write = 1'b0;
   logic [5:0]  dcache_address = 6'd0;
   logic [31:0] dcache_writedata = 32'd0;
   logic [31:0] dcache_readdata;
   logic        dcache_busywait;
   logic        icache_read = 1'b0;
   logic [5:0]  icache_address = 6'd0;
   logic [31:0] icache_readdata;
   logic        icache_busywait;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata = 32'd0;
   logic        mem_busywait = 1'b0;

   int errors = 0;
   int checks = 0;

   mem_arbiter dut (
      .clock(clock), .reset(reset),
      .dcache_read(dcache_read), .dcache_write(dcache_write),
      .dcache_address(dcache_address), .dcache_writedata(dcache_writedata),
      .dcache_readdata(dcache_readdata), .dcache_busywait(dcache_busywait),
      .icache_read(icache_read), .icache_address(icache_address),
      .icache_readdata(icache_readdata), .icache_busywait(icache_busywait),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
      .mem_busywait(mem_busywait)
   );

   always #5 clock = ~clock;

   // Transaction-level model: who owns memory, how long it has held it, who won last.
   localparam int NONE = 0;
   localparam int DC   = 1;
   localparam int IC   = 2;
   int owner       = NONE;
   int held_cycles = 0;
   int last_winner = IC;

   logic [5:0] grant_log[$];
   logic       prev_active = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic dreq;
      logic ireq;
      logic done;
      logic        e_rd;
      logic        e_wr;
      logic [5:0]  e_addr;
      logic [31:0] e_wd;
      dreq   = dcache_read | dcache_write;
      ireq   = icache_read;
      e_rd   = 1'b0;
      e_wr   = 1'b0;
      e_addr = 6'd0;
      e_wd   = 32'd0;
      done   = !reset && owner != NONE && held_cycles > 0 && !mem_busywait;
      if (!reset && owner == DC) begin
         e_wr   = dcache_write;
         e_rd   = !dcache_write;
         e_addr = dcache_address;
         e_wd   = dcache_writedata;
      end else if (!reset && owner == IC) begin
         e_rd   = 1'b1;
         e_addr = icache_address;
      end
      check("mem_read", 32'(mem_read), 32'(e_rd));
      check("mem_write", 32'(mem_write), 32'(e_wr));
      check("mem_address", 32'(mem_address), 32'(e_addr));
      check("mem_writedata", mem_writedata, e_wd);
      check("dcache_busywait", 32'(dcache_busywait), 32'(dreq && !(done && owner == DC)));
      check("icache_busywait", 32'(icache_busywait), 32'(ireq && !(done && owner == IC)));
      check("dcache_readdata", dcache_readdata, mem_readdata);
      check("icache_readdata", icache_readdata, mem_readdata);
   endtask

   task automatic advance_model();
      logic dreq;
      logic ireq;
      dreq = dcache_read | dcache_write;
      ireq = icache_read;
      if (reset) begin
         owner       = NONE;
         last_winner = IC;
      end else if (owner == NONE) begin
         if (dreq && ireq) owner = (last_winner == DC) ? IC : DC;
         else if (dreq)    owner = DC;
         else if (ireq)    owner = IC;
         if (owner != NONE) begin
            last_winner = owner;
            held_cycles = 0;
         end
      end else if (held_cycles == 0) begin
         held_cycles = 1;
      end else if (!mem_busywait) begin
         owner = NONE;
      end
   endtask

   // Inputs are changed just after a rising edge; outputs are checked on the falling edge.
   task automatic cyc(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         check_outputs();
         if ((mem_read || mem_write) && !prev_active) grant_log.push_back(mem_address);
         prev_active = mem_read | mem_write;
         @(posedge clock);
         advance_model();
         #1;
      end
   endtask

   initial begin
      // Reset state
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(1);

      // Lone dcache read, memory busy for several cycles
      dcache_read = 1'b1; dcache_address = 6'h15; mem_busywait = 1'b1; mem_readdata = 32'hDEADBEEF;
      cyc(6);
      mem_busywait = 1'b0;
      cyc(1);
      dcache_read = 1'b0;
      cyc(2);

      // Dcache write-back
      dcache_write = 1'b1; dcache_address = 6'h2A; dcache_writedata = 32'h12345678; mem_busywait = 1'b1;
      cyc(4);
      mem_busywait = 1'b0;
      cyc(1);
      dcache_write = 1'b0;
      cyc(2);

      // Simultaneous requests after reset, then continuous re-requests for fairness
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      grant_log.delete();
      prev_active = 1'b0;
      dcache_read = 1'b1; dcache_address = 6'h01;
      icache_read = 1'b1; icache_address = 6'h20;
      mem_busywait = 1'b0;
      cyc(12);
      dcache_read = 1'b0; icache_read = 1'b0;
      cyc(2);
      check("grant_count", 32'(grant_log.size()), 32'd4);
      if (grant_log.size() >= 4) begin
         check("grant0", 32'(grant_log[0]), 32'h01);
         check("grant1", 32'(grant_log[1]), 32'h20);
         check("grant2", 32'(grant_log[2]), 32'h01);
         check("grant3", 32'(grant_log[3]), 32'h20);
      end

      // Reset during D_WAIT aborts, then the held request is issued afresh
      dcache_read = 1'b1; dcache_address = 6'h07; mem_busywait = 1'b1;
      cyc(3);
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(3);
      mem_busywait = 1'b0;
      cyc(1);
      dcache_read = 1'b0;
      cyc(1);

      // Read and write together issue a write
      dcache_read = 1'b1; dcache_write = 1'b1; dcache_address = 6'h33; dcache_writedata = 32'hA5A5_5A5A;
      mem_busywait = 1'b1;
      cyc(3);
      mem_busywait = 1'b0;
      cyc(1);
      dcache_read = 1'b0; dcache_write = 1'b0;
      cyc(1);

      // Random traffic, including mid-transaction request changes and resets
      for (int n = 0; n < 400; n++) begin
         reset            = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 4) == 0) dcache_read  = 1'($urandom);
         if ($urandom_range(0, 6) == 0) dcache_write = 1'($urandom);
         if ($urandom_range(0, 4) == 0) icache_read  = 1'($urandom);
         dcache_address   = 6'($urandom);
         dcache_writedata = $urandom;
         icache_address   = 6'($urandom);
         mem_readdata     = $urandom;
         mem_busywait     = ($urandom_range(0, 9) < 6);
         cyc(1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have ports clock (input, 1, system clock) and reset (input, 1, synchronous, active-high); clock is clock and reset is reset.
REQ-002 The block SHALL have port dcache_read (input, 1, data-cache block read request).
REQ-003 The block SHALL have port dcache_write (input, 1, data-cache block write-back request).
REQ-004 The block SHALL have port dcache_address (input, 6, data-cache block address {tag,index}).
REQ-005 The block SHALL have port dcache_writedata (input, 32, data-cache write-back block).
REQ-006 The block SHALL have port dcache_readdata (output, 32, fetched block to the data cache).
REQ-007 The block SHALL have port dcache_busywait (output, 1, data-cache stall).
REQ-008 The block SHALL have port icache_read (input, 1, instruction-cache block read request).
REQ-009 The block SHALL have port icache_address (input, 6, instruction-cache block address).
REQ-010 The block SHALL have port icache_readdata (output, 32, fetched block to the instruction cache).
REQ-011 The block SHALL have port icache_busywait (output, 1, instruction-cache stall).
REQ-012 The block SHALL have ports mem_read (output, 1), mem_write (output, 1), mem_address (output, 6), mem_writedata (output, 32), mem_readdata (input, 32) and mem_busywait (input, 1), all connecting to the shared block memory.

Function
REQ-013 The block SHALL implement a registered FSM with states IDLE, D_ISSUE, D_WAIT, I_ISSUE and I_WAIT, plus a 1-bit register last_grant (0 = dcache, 1 = icache).
REQ-014 dreq SHALL equal dcache_read OR dcache_write, and ireq SHALL equal icache_read.
REQ-015 In IDLE, at a posedge with only dreq, the FSM SHALL move to D_ISSUE; with only ireq, it SHALL move to I_ISSUE; with neither, it SHALL stay in IDLE.
REQ-016 In IDLE, when dreq and ireq are both high, the requester not in last_grant SHALL win (round-robin), and last_grant SHALL be updated to the winner on the same edge.
REQ-017 Any x_ISSUE state SHALL advance unconditionally to x_WAIT after one cycle, during which mem_busywait is ignored.
REQ-018 x_WAIT SHALL hold while mem_busywait=1 and SHALL return to IDLE at the first posedge with mem_busywait=0.
REQ-019 There is no back-to-back grant: at least one IDLE cycle SHALL separate transactions.
REQ-020 In D_ISSUE/D_WAIT: mem_address=dcache_address and mem_writedata=dcache_writedata; if dcache_write=1, then mem_write=1 and mem_read=0 (write wins when both are set); otherwise mem_read=1 and mem_write=0.
REQ-021 In I_ISSUE/I_WAIT: mem_read=1, mem_write=0, mem_address=icache_address, mem_writedata=0.
REQ-022 In IDLE: mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
REQ-023 dcache_busywait SHALL equal dreq AND NOT(state==D_WAIT AND mem_busywait==0); icache_busywait SHALL be defined likewise with ireq and I_WAIT (combinational, so the requester samples data on the completing edge).
REQ-024 dcache_readdata and icache_readdata SHALL both be driven directly from mem_readdata.
REQ-025 If a requester deasserts its request mid-transaction, the block SHALL complete the memory transaction unchanged and return to IDLE.
REQ-026 Request-signal changes during a granted transaction SHALL NOT change the grant.

Reset
REQ-027 At a posedge with reset=1, state SHALL become IDLE and last_grant SHALL become 1, so dcache wins the first tie.
REQ-028 During reset, all mem_* outputs SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL abort the transaction: IDLE on the next edge and mem_read/mem_write=0, with no completion signalled to the requester.
REQ-030 Reset SHALL take priority over all other inputs.

Verification
REQ-031 Lone dcache read: dcache_read=1, addr=6'h15, memory busy for 5 cycles returning 32'hDEADBEEF -> mem_read=1, mem_address=6'h15 from D_ISSUE to completion; dcache_busywait falls in the completing cycle with dcache_readdata=32'hDEADBEEF; IDLE next.
REQ-032 Dcache write-back: dcache_write=1, addr=6'h2A, data=32'h12345678 -> mem_write=1, mem_read=0, mem_writedata=32'h12345678 until completion; icache_busywait stays 0 throughout.
REQ-033 Simultaneous requests after reset: dcache read 6'h01 and icache read 6'h20 both held -> dcache served first; one IDLE cycle; icache then served with mem_address=6'h20; icache_busywait stays 1 throughout the dcache transaction.
REQ-034 Fairness: both requesters re-request continuously for 4 transactions -> grant order D, I, D, I.
REQ-035 Reset during D_WAIT -> IDLE on the next edge, mem_read=0, dcache_busywait stays 1 while dcache_read is held, and a fresh D_ISSUE follows the release of reset.
REQ-036 Both dcache_read and dcache_write asserted -> a write transaction is issued (mem_write=1, mem_read=0).
